alu_arbiter_seq: RTL and testbench
==================================

// Module: alu_arbiter_seq
// PURPOSE
//  Shares one 4-bit ALU between two requesters (port 0 and port 1) with round-robin arbitration.
//  Each request carries a 3-bit opcode and two 4-bit operands.
//  The block latches the operands, runs the op for EXEC_CYCLES cycles, then holds an 8-bit result
//  until the consumer takes it.
//  Sits between switch/key front-ends and the LEDR/HEX display path.
// PARAMETERS
//  EXEC_CYCLES  2  cycles spent in EXEC per op; legal range 1..15
// PORTS
//  clock       in   1  system clock; all state changes on the rising edge
//  resetn      in   1  asynchronous, active-low reset
//  req0_valid  in   1  requester 0 has an op pending
//  req0_op     in   3  requester 0 opcode
//  req0_a      in   4  requester 0 operand A
//  req0_b      in   4  requester 0 operand B
//  req0_ready  out  1  requester 0 op accepted this cycle when high together with req0_valid
//  req1_valid, req1_op, req1_a, req1_b, req1_ready: same as port 0, for requester 1
//  res_valid   out  1  result held and valid
//  res_data    out  8  result value
//  res_id      out  1  requester that owns res_data (0 or 1)
//  res_ready   in   1  consumer takes the result
//  busy        out  1  high in EXEC or DONE
// BEHAVIOUR
//  Reset: one clock, one asynchronous active-low reset.
//  - While resetn is low: state=IDLE, res_valid=0, res_data=0, res_id=0, busy=0, both readys=0,
//    exec counter=0, round-robin pointer=0 (port 0 has priority).
//  - Reset mid-EXEC or mid-DONE discards the op. No res_valid is produced for it.
//  FSM states: IDLE, EXEC, DONE.
//  - IDLE:
//    - grant = pointer port if its valid is high; else the other port if its valid is high; else none.
//    - reqK_ready = (state==IDLE) & grant==K. This is combinational; at most one ready is high.
//    - On accept: latch op/a/b/id, set counter=EXEC_CYCLES-1, go to EXEC, set pointer=~id.
//  - EXEC:
//    - Counter decrements each cycle.
//    - When the counter is 0: register res_data from the latched operands, set res_valid=1,
//      go to DONE.
//  - DONE:
//    - res_valid, res_data and res_id are held stable while res_ready is low.
//    - On res_ready=1: res_valid=0, go to IDLE.
//    - No request is accepted in the DONE cycle itself.
//  Latency: accept at edge N, then res_valid=1 after edge N+EXEC_CYCLES.
//  Throughput: minimum 2+EXEC_CYCLES cycles per op.
//  Ops: A, B are 4-bit unsigned. Adds are 5-bit and zero-extended to 8 bits.
//  - 000: A+1
//  - 001: A+B
//  - 010: A+B
//  - 011: {A^B, A|B}, where A^B is bits 7:4
//  - 100: {7'b0, |{A,B}}
//  - 101: {A,B}
//  - 110, 111: 8'h00
//  Input changes while not in IDLE are ignored, because operands are latched.
//  A requester that drops valid before ready is simply not served; no error is raised.
//  Both valid in the same cycle: the pointer port wins.
//  - The loser is served next, provided it still holds valid once the block is back in IDLE.
//  - Port 0 and port 1 alternate under continuous contention.
//  busy = (state != IDLE).
// TESTING
//  - Reset, then req0 op=001 a=9 b=8 with res_ready=1 -> res_valid after EXEC_CYCLES cycles;
//    res_data=8'h11, res_id=0.
//  - op=011 a=4'hC b=4'hA -> 8'h6E.
//  - op=000 a=4'hF -> 8'h10.
//  - op=100 a=0 b=0 -> 8'h00.
//  - op=101 a=3 b=5 -> 8'h35.
//  - op=111 -> 8'h00.
//  - Both ports valid continuously with res_ready=1 -> result order is id 0,1,0,1,
//    and only one ready is high in any cycle.
//  - Hold res_ready=0 for 10 cycles in DONE -> res_valid, res_data and res_id are stable,
//    both readys stay 0, busy=1. Then raise res_ready -> IDLE on the next edge.
//  - Change req0_a/b during EXEC -> result is computed from the operands at accept time.
//  - Assert resetn=0 mid-EXEC, then release -> no res_valid, pointer=0, req0 is granted first.

Source files
------------

// File: rtl/alu_arbiter_seq.sv
// Two-port round-robin front end sharing one small ALU; operands are latched on accept,
// the op runs for EXEC_CYCLES cycles, and the 8-bit result is held until the consumer takes it.
module alu_arbiter_seq #(
   parameter int EXEC_CYCLES = 2
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       req0_valid,
   input  logic [2:0] req0_op,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [2:0] req1_op,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       req1_ready,
   output logic       res_valid,
   output logic [7:0] res_data,
   output logic       res_id,
   input  logic       res_ready,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt;
   logic       ptr;
   logic [2:0] op_q;
   logic [3:0] a_q, b_q;
   logic       id_q;
   logic       grant_any, grant_id;
   logic       accept;

   function automatic logic [7:0] alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      case (op)
         3'b000:  alu = {3'b000, {1'b0, a} + 5'd1};
         3'b001,
         3'b010:  alu = {3'b000, sum};
         3'b011:  alu = {a ^ b, a | b};
         3'b100:  alu = {7'b0, |{a, b}};
         3'b101:  alu = {a, b};
         default: alu = 8'h00;
      endcase
   endfunction

   // Pointer port wins ties; the other port is taken only when the pointer port is idle.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = 1'b0;
      if (ptr ? req1_valid : req0_valid) begin
         grant_any = 1'b1;
         grant_id  = ptr;
      end else if (ptr ? req0_valid : req1_valid) begin
         grant_any = 1'b1;
         grant_id  = ~ptr;
      end
   end

   assign accept     = (state == IDLE) && grant_any;
   // Gated by resetn so neither ready can fire while reset is held.
   assign req0_ready = resetn && accept && !grant_id;
   assign req1_ready = resetn && accept &&  grant_id;
   assign busy       = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    if (cnt == 4'd0) state_nxt = DONE;
         DONE:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         ptr       <= 1'b0;
         op_q      <= 3'b000;
         a_q       <= 4'd0;
         b_q       <= 4'd0;
         id_q      <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= 8'h00;
         res_id    <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (accept) begin
               op_q <= grant_id ? req1_op : req0_op;
               a_q  <= grant_id ? req1_a  : req0_a;
               b_q  <= grant_id ? req1_b  : req0_b;
               id_q <= grant_id;
               cnt  <= CNT_LOAD;
               ptr  <= ~grant_id;
            end
            EXEC: if (cnt == 4'd0) begin
               res_data  <= alu(op_q, a_q, b_q);
               res_id    <= id_q;
               res_valid <= 1'b1;
            end else begin
               cnt <= cnt - 4'd1;
            end
            DONE: if (res_ready) res_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Directed bench for alu_arbiter_seq: opcode table, contention order, DONE hold,
// operand latching and mid-EXEC reset.
module tb_alu_arbiter_seq;

   localparam int EXEC_CYCLES = 2;

   logic       clock, resetn;
   logic       req0_valid, req1_valid, req0_ready, req1_ready;
   logic [2:0] req0_op, req1_op;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic       res_valid, res_id, res_ready, busy;
   logic [7:0] res_data;

   int checks = 0;
   int errors = 0;

   alu_arbiter_seq #(.EXEC_CYCLES(EXEC_CYCLES)) dut (
      .clock(clock), .resetn(resetn),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       port;
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic port, input logic v, input logic [2:0] op,
                        input logic [3:0] a, input logic [3:0] b);
      if (port) begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
      end
   endtask

   // Entered at posedge+1 in IDLE with res_ready=1; leaves at posedge+1 back in IDLE.
   task automatic do_op(input logic port, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] exp);
      logic early;
      early = 1'b0;
      drive(port, 1'b1, op, a, b);
      #1;
      chk("ready", {30'd0, req1_ready, req0_ready}, port ? 32'd2 : 32'd1);
      @(posedge clock); #1;
      drive(port, 1'b0, op, a, b);
      for (int k = 1; k < EXEC_CYCLES; k++) begin
         @(posedge clock); #1;
         if (res_valid) early = 1'b1;
      end
      chk("latency_early", {31'd0, early}, 32'd0);
      @(posedge clock); #1;
      chk("result", {22'd0, res_valid, res_id, res_data}, {22'd0, 1'b1, port, exp});
      @(posedge clock); #1;
      chk("back_idle", {30'd0, busy, res_valid}, 32'd0);
   endtask

   initial begin
      int n, overlap, found;
      logic [1:0] ids[4];
      logic [7:0] dats[4];

      vecs[0] = '{1'b0, 3'b001, 4'h9, 4'h8, 8'h11};
      vecs[1] = '{1'b0, 3'b011, 4'hC, 4'hA, 8'h6E};
      vecs[2] = '{1'b0, 3'b000, 4'hF, 4'h0, 8'h10};
      vecs[3] = '{1'b0, 3'b100, 4'h0, 4'h0, 8'h00};
      vecs[4] = '{1'b0, 3'b101, 4'h3, 4'h5, 8'h35};
      vecs[5] = '{1'b0, 3'b111, 4'h7, 4'h9, 8'h00};
      vecs[6] = '{1'b1, 3'b110, 4'hF, 4'hF, 8'h00};
      vecs[7] = '{1'b1, 3'b010, 4'hF, 4'hF, 8'h1E};
      vecs[8] = '{1'b0, 3'b100, 4'h0, 4'h1, 8'h01};
      vecs[9] = '{1'b1, 3'b011, 4'h5, 4'h3, 8'h67};

      resetn = 1'b0; res_ready = 1'b1;
      drive(1'b0, 1'b1, 3'b001, 4'h1, 4'h1);
      drive(1'b1, 1'b1, 3'b001, 4'h1, 4'h1);
      repeat (2) @(posedge clock);
      #1;
      chk("reset_state", {19'd0, res_valid, res_data, res_id, busy, req0_ready, req1_ready},
          32'd0);

      // Contention straight out of reset: port 0 first, then strict alternation.
      drive(1'b0, 1'b1, 3'b101, 4'h1, 4'h2);
      drive(1'b1, 1'b1, 3'b101, 4'h3, 4'h4);
      #2 resetn = 1'b1;
      @(posedge clock); #1;
      n = 0; overlap = 0;
      for (int c = 0; c < 60 && n < 4; c++) begin
         if (req0_ready && req1_ready) overlap++;
         if (res_valid) begin
            ids[n] = {1'b0, res_id};
            dats[n] = res_data;
            n++;
         end
         if (n < 4) begin
            @(posedge clock); #1;
         end
      end
      drive(1'b0, 1'b0, 3'b000, 4'h0, 4'h0);
      drive(1'b1, 1'b0, 3'b000, 4'h0, 4'h0);
      chk("rr_count", n, 4);
      chk("rr_one_ready", overlap, 0);
      if (n == 4) begin
         chk("rr_order", {24'd0, ids[0], ids[1], ids[2], ids[3]}, {24'd0, 8'b00_01_00_01});
         chk("rr_data", {dats[0], dats[1], dats[2], dats[3]}, 32'h12341234);
      end
      @(posedge clock); #1;

      for (int i = 0; i < 10; i++)
         do_op(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

      // DONE hold with res_ready low and both requesters pending.
      res_ready = 1'b0;
      drive(1'b0, 1'b1, 3'b011, 4'hC, 4'hA);
      @(posedge clock); #1;
      drive(1'b0, 1'b1, 3'b101, 4'h1, 4'h1);
      drive(1'b1, 1'b1, 3'b101, 4'h2, 4'h2);
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (res_valid) found = 1;
         else begin
            @(posedge clock); #1;
         end
      end
      chk("hold_reach_done", found, 1);
      for (int c = 0; c < 10; c++) begin
         @(posedge clock); #1;
         chk("hold_stable", {20'd0, res_valid, res_data, res_id, req0_ready, req1_ready, busy},
             {20'd0, 1'b1, 8'h6E, 1'b0, 1'b0, 1'b0, 1'b1});
      end
      drive(1'b0, 1'b0, 3'b000, 4'h0, 4'h0);
      drive(1'b1, 1'b0, 3'b000, 4'h0, 4'h0);
      res_ready = 1'b1;
      @(posedge clock); #1;
      chk("hold_release", {30'd0, busy, res_valid}, 32'd0);

      // Operands changed during EXEC must not affect the result.
      drive(1'b0, 1'b1, 3'b001, 4'h9, 4'h8);
      @(posedge clock); #1;
      req0_valid = 1'b0; req0_a = 4'hF; req0_b = 4'hF; req0_op = 3'b101;
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(posedge clock); #1;
         if (res_valid) found = 1;
      end
      chk("latch_operands", {23'd0, found[0], res_data}, {23'd0, 1'b1, 8'h11});
      @(posedge clock); #1;

      // Reset mid-EXEC: op dropped, pointer back to port 0.
      drive(1'b0, 1'b1, 3'b101, 4'h7, 4'h7);
      @(posedge clock); #1;
      drive(1'b0, 1'b0, 3'b000, 4'h0, 4'h0);
      chk("rst_in_exec", {31'd0, busy}, 32'd1);
      resetn = 1'b0;
      #2;
      chk("rst_async", {30'd0, busy, res_valid}, 32'd0);
      #2 resetn = 1'b1;
      found = 0;
      for (int c = 0; c < EXEC_CYCLES + 3; c++) begin
         @(posedge clock); #1;
         if (res_valid || busy) found = 1;
      end
      chk("rst_no_result", found, 0);
      drive(1'b0, 1'b1, 3'b000, 4'h2, 4'h0);
      drive(1'b1, 1'b1, 3'b000, 4'h4, 4'h0);
      #1;
      chk("rst_ptr_port0", {30'd0, req1_ready, req0_ready}, 32'd1);
      @(posedge clock); #1;
      drive(1'b0, 1'b0, 3'b000, 4'h0, 4'h0);
      drive(1'b1, 1'b0, 3'b000, 4'h0, 4'h0);
      repeat (EXEC_CYCLES) @(posedge clock);
      #1;
      chk("rst_first_result", {22'd0, res_valid, res_id, res_data}, {22'd0, 1'b1, 1'b0, 8'h03});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
